product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream consumer of the low-power 8x8 multiplier's 16-bit unsigned products. Accumulates a group of products (one dot-product), then requantizes the sum to 8 bits with a configurable right shift, round-half-up and saturation. Results leave on a valid/ready interface toward the activation and writeback stage. Groups are delimited by `in_last`. While a result waits for `out_ready`, input is back-pressured, which lets the upstream enable logic gate the multiplier clock.

## Interface
- `PROD_W`, 16: product width; must match the multiplier output.
- `ACC_W`, 24: accumulator width; exact for groups of up to 256 products.
- `OUT_W`, 8: requantized result width.
- `CNT_W`, 9: group beat-counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: product beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_data` in PROD_W: unsigned product.
- `in_last` in 1: beat is the last of its group.
- `cfg_shift` in 5: right-shift amount; sampled on the accepted last beat; values > ACC_W-1 clamp to ACC_W-1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out OUT_W: requantized, saturated result.
- `out_sat` out 1: result was clipped, or the accumulator overflowed, in this group.
- `out_count` out CNT_W: number of beats in the group; saturates at all-ones.

## Operation
- Two states: ACCUM and HOLD.
- `in_ready` = (state == ACCUM).
- `out_valid` = (state == HOLD).
- Accept occurs when `in_valid && in_ready`.

ACCUM, accept without `in_last`:
- acc <= acc + in_data, saturating at 2^ACC_W-1.
- ovf sticky <= ovf | carry.
- cnt <= cnt+1, saturating.

ACCUM, accept with `in_last`:
- The final sum s = acc + in_data is formed, with overflow folded into ovf.
- Requantization: r = (s + (sh ? 1<<(sh-1) : 0)) >> sh, computed in ACC_W+1 bits so the rounding add cannot wrap.
- `out_data` <= min(r, 2^OUT_W-1).
- `out_sat` <= ovf | (r > 2^OUT_W-1).
- `out_count` <= cnt+1, saturating.
- acc, cnt and ovf clear; state goes to HOLD.

HOLD:
- Outputs are held stable.
- On `out_ready`, state goes to ACCUM.
- `out_data`, `out_sat` and `out_count` keep their last values after the handshake; they are only meaningful while `out_valid` is high.

Boundary conditions:
- A group of one beat (`in_last` on the first beat) is legal and gives `out_count` = 1.
- `in_valid` during HOLD is ignored. Upstream must hold the beat, since `in_ready` is low.
- `cfg_shift` changes mid-group have no effect; only the value on the last beat counts.
- Reset mid-group or during HOLD discards all state with no output.

Reset values:
- state ACCUM.
- acc, cnt, ovf = 0.
- `out_valid` = 0, `out_data` = 0, `out_sat` = 0, `out_count` = 0.
- `in_ready` is 1 from the first cycle after reset deasserts.

## Timing
- Accept throughput: one beat per cycle in ACCUM.
- Latency: last beat accepted at edge t gives `out_valid` high after edge t; data is registered, with no combinational input-to-output path.
- Result handshake at edge u gives `in_ready` high after edge u. Minimum group period is N+1 cycles.
- `in_ready` depends only on state, never combinationally on `out_ready`.
- `rst` has priority over every handshake in the same cycle.

## Structure
- Package `product_acc_pkg`:
  - state enum {ACCUM, HOLD};
  - default width constants PROD_W/ACC_W/OUT_W/CNT_W;
  - shift-clamp constant.
- Sub-module `requant_sat`: purely combinational round, shift, clamp and saturation-flag generation. Parameterised on ACC_W/OUT_W; unit-testable alone.
- Top level holds the FSM, accumulator, counter and output registers.

## Test plan
- Single group: products 100, 200, 300, last; shift 0; out_ready=1. Expect out_data=255, out_sat=1, out_count=3, out_valid one cycle after the last accept.
- Rounding: products 6, 1 (sum 7), shift 1. Expect r=(7+1)>>1=4, out_data=4, out_sat=0. Repeat with sum 5 and shift 2: expect 1.
- Back-pressure: group completes with out_ready=0 for 5 cycles. Expect out_valid, out_data and out_count stable, in_ready=0 throughout, and in_ready=1 the cycle after out_ready rises. The held input beat is then accepted exactly once.
- Overflow: 300 beats of 65535, shift 23. Expect acc pinned at 2^24-1, out_sat=1, out_count=300, out_data=2 (round-up of (2^24-1)>>23).
- Reset mid-group: 2 beats accepted, rst pulsed, then a 1-beat group of 9 with shift 0. Expect out_data=9, out_count=1, out_sat=0, and no output from the aborted group.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the product accumulator and its requantizer.
// Products are unsigned multiplier outputs; the accumulator is wide enough for 256 exact beats.
package product_acc_pkg;

  localparam int PROD_W  = 16;
  localparam int ACC_W   = 24;
  localparam int OUT_W   = 8;
  localparam int CNT_W   = 9;
  localparam int SHIFT_W = 5;

  // Largest meaningful right shift for the default accumulator width.
  localparam int SHIFT_MAX = ACC_W - 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sh,
                                                     input int max_sh);
    return (int'(sh) > max_sh) ? SHIFT_W'(max_sh) : sh;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-beat input stream plus requantized result stream, grouped as one bundle.
// master = upstream/downstream environment, slave = the accumulator block.
interface product_accumulator_if #(
  parameter int PROD_W = product_acc_pkg::PROD_W,
  parameter int OUT_W  = product_acc_pkg::OUT_W,
  parameter int CNT_W  = product_acc_pkg::CNT_W
) ();
  import product_acc_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [PROD_W-1:0]   in_data;
  logic                in_last;
  logic [SHIFT_W-1:0]  cfg_shift;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_sat;
  logic [CNT_W-1:0]    out_count;

  modport master (
    output in_valid, in_data, in_last, cfg_shift, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, cfg_shift, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );

endinterface

// File: rtl/product_accumulator_requant_sat.sv
// Combinational requantizer: clamp shift, round half up, shift right, saturate to OUT_W.
// The rounding add is one bit wider than the sum so it can never wrap.
module requant_sat #(
  parameter int ACC_W   = product_acc_pkg::ACC_W,
  parameter int OUT_W   = product_acc_pkg::OUT_W,
  parameter int SHIFT_W = product_acc_pkg::SHIFT_W
) (
  input  logic [ACC_W-1:0]   sum_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               ovf_i,
  output logic [OUT_W-1:0]   data_o,
  output logic               sat_o
);
  import product_acc_pkg::*;

  localparam int RND_W = ACC_W + 1;
  localparam logic [RND_W-1:0] OUT_MAX = {{(RND_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [SHIFT_W-1:0] sh;
  logic [RND_W-1:0]   rnd;
  logic [RND_W-1:0]   biased;
  logic [RND_W-1:0]   r;
  logic               clip;

  always_comb begin
    sh  = clamp_shift(shift_i, ACC_W - 1);
    rnd = '0;
    if (sh != '0) begin
      rnd = RND_W'(1) << (sh - SHIFT_W'(1));
    end
    biased = {1'b0, sum_i} + rnd;
    r      = biased >> sh;
    clip   = (r > OUT_MAX);
    data_o = clip ? {OUT_W{1'b1}} : r[OUT_W-1:0];
    sat_o  = ovf_i | clip;
  end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a group of unsigned products, then presents one requantized 8-bit result.
// While the result is held, in_ready stays low so upstream can stall the multiplier.
module product_accumulator #(
  parameter int PROD_W = product_acc_pkg::PROD_W,
  parameter int ACC_W  = product_acc_pkg::ACC_W,
  parameter int OUT_W  = product_acc_pkg::OUT_W,
  parameter int CNT_W  = product_acc_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);
  import product_acc_pkg::*;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_sat_q, out_sat_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;

  logic               accept;
  logic [ACC_W:0]     sum_wide;
  logic               carry;
  logic [ACC_W-1:0]   sum_sat;
  logic [CNT_W-1:0]   cnt_inc;
  logic [OUT_W-1:0]   rq_data;
  logic               rq_sat;

  always_comb begin
    accept   = bus.in_valid && (state_q == ACCUM);
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'(bus.in_data);
    carry    = sum_wide[ACC_W];
    sum_sat  = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Overflow on the final beat itself must also reach the sat flag.
  requant_sat #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .sum_i   (sum_sat),
    .shift_i (bus.cfg_shift),
    .ovf_i   (ovf_q | carry),
    .data_o  (rq_data),
    .sat_o   (rq_sat)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    out_count_d = out_count_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (bus.in_last) begin
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
            out_count_d = cnt_inc;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d = sum_sat;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a reference model pushes expected results
// per group, and a monitor pops and compares them on each result handshake.
module tb_product_accumulator;
  import product_acc_pkg::*;

  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  product_accumulator_if ifc ();

  product_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    int unsigned data;
    int unsigned sat;
    int unsigned count;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned beats[$];
  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent reference: saturating sum, clamped shift, round half up, clip to 8 bits.
  function automatic exp_t model_group(input int unsigned sh_in);
    longint unsigned acc = 0;
    longint unsigned r;
    longint unsigned rnd;
    bit              ovf = 1'b0;
    int unsigned     sh;
    exp_t            e;
    foreach (beats[i]) begin
      acc += beats[i];
      if (acc > ACC_MAX) begin
        acc = ACC_MAX;
        ovf = 1'b1;
      end
    end
    sh  = (sh_in > 23) ? 23 : sh_in;
    rnd = (sh == 0) ? 64'd0 : (64'd1 << (sh - 1));
    r   = (acc + rnd) >> sh;
    e.data  = (r > 255) ? 255 : int'(r);
    e.sat   = (ovf || (r > 255)) ? 1 : 0;
    e.count = (beats.size() > 511) ? 511 : beats.size();
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_beat(input int unsigned d, input logic last, input int unsigned sh);
    int waited = 0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'(d);
    ifc.in_last   = last;
    ifc.cfg_shift = 5'(sh);
    while (!ifc.in_ready && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 2000) begin
      check_value("accept_timeout", 32'(ifc.in_ready), 32'd1);
    end
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic run_group(input int unsigned sh, input bit push);
    if (push) sb_q.push_back(model_group(sh));
    $display("GROUP beats=%0d shift=%0d scored=%0d", beats.size(), sh, push);
    foreach (beats[i]) begin
      if (i == beats.size() - 1) send_beat(beats[i], 1'b1, sh);
      else                       send_beat(beats[i], 1'b0, $urandom_range(0, 31));
    end
  endtask

  task automatic wait_idle();
    int waited = 0;
    while ((sb_q.size() != 0 || ifc.out_valid) && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 200) check_value("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (sb_q.size() == 0) begin
        check_value("unexpected_out", 32'(ifc.out_valid), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("OUT data=%0d sat=%0d count=%0d (exp %0d/%0d/%0d)", ifc.out_data, ifc.out_sat,
                 ifc.out_count, mon_e.data, mon_e.sat, mon_e.count);
        check_value("out_data", 32'(ifc.out_data), mon_e.data);
        check_value("out_sat", 32'(ifc.out_sat), mon_e.sat);
        check_value("out_count", 32'(ifc.out_count), mon_e.count);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) ifc.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.cfg_shift = '0;
    ifc.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check_value("rst_out_data", 32'(ifc.out_data), 32'd0);
    check_value("rst_out_sat", 32'(ifc.out_sat), 32'd0);
    check_value("rst_out_count", 32'(ifc.out_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_value("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;

    // Single group with clipping; result valid right after the last accept.
    beats = {100, 200, 300};
    run_group(0, 1);
    check_value("lat_valid", 32'(ifc.out_valid), 32'd1);
    check_value("lat_in_ready", 32'(ifc.in_ready), 32'd0);
    wait_idle();

    // Rounding cases.
    beats = {6, 1};  run_group(1, 1); wait_idle();
    beats = {2, 3};  run_group(2, 1); wait_idle();
    beats = {4, 2};  run_group(2, 1); wait_idle();
    beats = {77};    run_group(0, 1); wait_idle();

    // Back-pressure: held result, stalled input beat accepted exactly once.
    ifc.out_ready = 1'b0;
    beats = {10, 20};
    run_group(1, 1);
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'd40;
    ifc.in_last   = 1'b1;
    ifc.cfg_shift = 5'd0;
    beats = {40};
    sb_q.push_back(model_group(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_value("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      check_value("bp_in_ready", 32'(ifc.in_ready), 32'd0);
      check_value("bp_out_data", 32'(ifc.out_data), 32'd15);
      check_value("bp_out_count", 32'(ifc.out_count), 32'd2);
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check_value("bp_ready_not_comb", 32'(ifc.in_ready), 32'd0);
    @(posedge clk); #1;
    check_value("bp_ready_after", 32'(ifc.in_ready), 32'd1);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    check_value("bp_held_beat_hold", 32'(ifc.out_valid), 32'd1);
    wait_idle();

    // Overflow: accumulator pins at max; also with an out-of-range shift that clamps to 23.
    beats.delete();
    repeat (300) beats.push_back(65535);
    run_group(23, 1); wait_idle();
    run_group(31, 1); wait_idle();

    // Reset mid-group discards the partial sum.
    send_beat(5, 1'b0, 0);
    send_beat(7, 1'b0, 0);
    pulse_reset();
    check_value("abort_no_valid", 32'(ifc.out_valid), 32'd0);
    beats = {9};
    run_group(0, 1);
    wait_idle();

    // Reset during HOLD drops the pending result.
    ifc.out_ready = 1'b0;
    beats = {50};
    run_group(0, 0);
    check_value("hold_pre_rst_valid", 32'(ifc.out_valid), 32'd1);
    pulse_reset();
    check_value("hold_rst_valid", 32'(ifc.out_valid), 32'd0);
    check_value("hold_rst_count", 32'(ifc.out_count), 32'd0);
    ifc.out_ready = 1'b1;

    // Random groups with random result back-pressure.
    rand_ready = 1'b1;
    for (int g = 0; g < 24; g++) begin
      int n;
      n = $urandom_range(1, 8);
      beats.delete();
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 1) != 0) beats.push_back($urandom_range(0, 65535));
        else                           beats.push_back($urandom_range(0, 40));
      end
      run_group($urandom_range(0, 31), 1);
    end
    rand_ready = 1'b0;
    ifc.out_ready = 1'b1;
    wait_idle();

    repeat (3) @(posedge clk);
    check_value("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
